// File: rtl/multicycle_alu.sv
// multicycle_alu: valid/ready ALU. Single-cycle ops produce a registered
// result one edge after acceptance. MUL runs an iterative shift-add
// multiplier over WIDTH cycles. The result and flags stay stable while the
// consumer stalls.
module multicycle_alu #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ZERO,
  output logic             NEG,
  output logic             CARRY,
  output logic             OVF,
  output logic             ERR
);

  // Shift-amount width, derived from WIDTH.
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_FWD = 4'h0,
    OP_ADD = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_SLL = 4'h4,
    OP_SRL = 4'h5,
    OP_MUL = 4'h6,
    OP_ROR = 4'h7,
    OP_SUB = 4'h8,
    OP_SRA = 4'h9,
    OP_XOR = 4'hA,
    OP_SLT = 4'hB
  } op_e;

  state_e state_q, state_d;

  // Multiplier state. acc holds the partial product, mcand is the shifted
  // multiplicand, and mplier is consumed from its LSB.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  // Presented result and flags.
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  // Handshake and control.
  logic in_ready;
  logic out_free;
  logic is_mul_op;
  logic accept_mul;
  logic mul_last;
  logic load_alu;
  logic load_mul;

  // Single-cycle datapath.
  logic [SHW-1:0]     sh_amt;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [2*WIDTH-1:0] sll_wide;
  logic [2*WIDTH-1:0] srl_wide;
  logic [2*WIDTH-1:0] ror_wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic               alu_err;

  // Multiplier step and the product source used when results are loaded.
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] mul_src;
  logic [WIDTH-1:0]   res_new;
  logic               carry_new;
  logic               ovf_new;
  logic               err_new;

  assign out_free   = !out_valid_q || OUT_READY;
  assign is_mul_op  = (OP == OP_MUL);
  assign accept_mul = in_ready && IN_VALID && is_mul_op;
  assign mul_last   = (cnt_q == SHW'(WIDTH - 1));
  assign mul_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
  // In HOLD the final product was already written into acc on the last step.
  assign mul_src    = (state_q == S_HOLD) ? acc_q : mul_step;

  // The wide shifts keep the bit that falls off, which gives the shift carry
  // directly. That bit is naturally 0 when the shift amount is 0.
  assign sh_amt   = DATA2[SHW-1:0];
  assign add_full = {1'b0, DATA1} + {1'b0, DATA2};
  assign sub_full = {1'b0, DATA1} - {1'b0, DATA2};
  assign sll_wide = {{WIDTH{1'b0}}, DATA1} << sh_amt;
  assign srl_wide = {DATA1, {WIDTH{1'b0}}} >> sh_amt;
  assign ror_wide = {DATA1, DATA1} >> sh_amt;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept_mul) state_d = S_MUL;
      S_MUL:  if (mul_last)   state_d = out_free ? S_IDLE : S_HOLD;
      S_HOLD: if (OUT_READY)  state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // FSM outputs: input readiness and the two result-load strobes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    in_ready = 1'b0;
    load_alu = 1'b0;
    load_mul = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = out_free;
        load_alu = IN_VALID && out_free && !is_mul_op;
      end
      S_MUL:  load_mul = mul_last && out_free;
      S_HOLD: load_mul = OUT_READY;
      default: ;
    endcase
  end

  // Single-cycle ALU: result and op-specific carry/overflow/error.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (OP)
      OP_FWD: alu_res = DATA2;
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        alu_ovf   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) &&
                    (add_full[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_AND: alu_res = DATA1 & DATA2;
      OP_OR:  alu_res = DATA1 | DATA2;
      OP_SLL: begin
        alu_res   = sll_wide[WIDTH-1:0];
        alu_carry = sll_wide[WIDTH];
      end
      OP_SRL: begin
        alu_res   = srl_wide[2*WIDTH-1:WIDTH];
        alu_carry = srl_wide[WIDTH-1];
      end
      OP_ROR: alu_res = ror_wide[WIDTH-1:0];
      OP_SUB: begin
        alu_res   = sub_full[WIDTH-1:0];
        alu_carry = sub_full[WIDTH];
        alu_ovf   = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) &&
                    (sub_full[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_SRA: alu_res = $unsigned($signed(DATA1) >>> sh_amt);
      OP_XOR: alu_res = DATA1 ^ DATA2;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(DATA1) < $signed(DATA2))};
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Result/flag next-state logic: load on either strobe, otherwise hold.
  always_comb begin
    if (load_alu) begin
      res_new   = alu_res;
      carry_new = alu_carry;
      ovf_new   = alu_ovf;
      err_new   = alu_err;
    end else begin
      res_new   = mul_src[WIDTH-1:0];
      carry_new = 1'b0;
      ovf_new   = |mul_src[2*WIDTH-1:WIDTH];
      err_new   = 1'b0;
    end

    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (load_alu || load_mul) begin
      result_d = res_new;
      zero_d   = (res_new == '0);
      neg_d    = res_new[WIDTH-1];
      carry_d  = carry_new;
      ovf_d    = ovf_new;
      err_d    = err_new;
    end

    if (load_alu || load_mul) out_valid_d = 1'b1;
    else if (OUT_READY)       out_valid_d = 1'b0;
    else                      out_valid_d = out_valid_q;
  end

  // Multiplier next-state: capture operands on accept, step once per MUL cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (accept_mul) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, DATA1};
      mplier_d = DATA2;
      cnt_d    = '0;
    end else if (state_q == S_MUL) begin
      acc_d    = mul_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous and this block holds only plain registers
    // with no array storage, so every register is cleared explicitly here.
    if (!RESET_N) begin
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = in_ready;
  assign RESULT    = result_q;
  assign OUT_VALID = out_valid_q;
  assign ZERO      = zero_q;
  assign NEG       = neg_q;
  assign CARRY     = carry_q;
  assign OVF       = ovf_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=8). The expected results
// come from directed constants and from an arithmetic reference model.
module tb_multicycle_alu;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         o;
    logic         e;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         IN_VALID;
  logic         IN_READY;
  logic [3:0]   OP;
  logic [W-1:0] DATA1;
  logic [W-1:0] DATA2;
  logic [W-1:0] RESULT;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic         ZERO, NEG, CARRY, OVF, ERR;

  int checks   = 0;
  int failures = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .OP       (OP),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .RESULT   (RESULT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .ZERO     (ZERO),
    .NEG      (NEG),
    .CARRY    (CARRY),
    .OVF      (OVF),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t observed();
    return '{res: RESULT, z: ZERO, n: NEG, c: CARRY, o: OVF, e: ERR};
  endfunction

  // Reference model. It works in plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    longint mask = (longint'(1) << W) - 1;
    longint smax = (longint'(1) << (W - 1)) - 1;
    longint smin = -(longint'(1) << (W - 1));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    longint sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    int     sh = int'(ub % W);
    longint r = 0;
    longint s = 0;
    exp_t   m;
    m = '0;
    case (op)
      4'h0: r = ub;
      4'h1: begin
        r = ua + ub; m.c = (r > mask);
        s = sa + sb; m.o = (s > smax) || (s < smin);
      end
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: begin r = ua << sh; m.c = (sh != 0) && (((ua >> (W - sh)) & 1) == 1); end
      4'h5: begin r = ua >> sh; m.c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      4'h6: begin r = ua * ub; m.o = (r > mask); end
      4'h7: r = (ua >> sh) | (ua << (W - sh));
      4'h8: begin
        r = ua - ub; m.c = (ua < ub);
        s = sa - sb; m.o = (s > smax) || (s < smin);
      end
      4'h9: r = sa >>> sh;
      4'hA: r = ua ^ ub;
      4'hB: r = (sa < sb) ? 1 : 0;
      default: begin r = 0; m.e = 1'b1; end
    endcase
    r     = r & mask;
    m.res = r[W-1:0];
    m.z   = (m.res == '0);
    m.n   = m.res[W-1];
    return m;
  endfunction

  // Presents one request with OUT_READY=1 and waits for its result.
  // extra = edges after the accepting edge until OUT_VALID appears.
  // busy  = samples with IN_READY low while waiting.
  task automatic issue_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output exp_t obs,
                          output int extra, output int busy);
    int guard = 0;
    OUT_READY = 1'b1;
    while (!IN_READY && guard < 50) begin @(posedge CLK); #1; guard++; end
    IN_VALID = 1'b1; OP = op; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    OP = 4'($urandom); DATA1 = W'($urandom); DATA2 = W'($urandom);
    extra = 0; busy = 0;
    while (!OUT_VALID && extra < 40) begin
      if (!IN_READY) busy++;
      @(posedge CLK); #1; extra++;
    end
    obs = observed();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; IN_VALID = 1'b1; OP = 4'h1; DATA1 = 8'h7F; DATA2 = 8'h01;
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || observed() !== exp_t'(0)) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b outs=%h, required out_valid=0 outs=%h",
               OUT_VALID, observed(), exp_t'(0));
    end
    RESET_N = 1'b1; IN_VALID = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_directed();
    logic [3:0]   t_op  [15] = '{4'h1, 4'h9, 4'h7, 4'h4, 4'h4, 4'hB, 4'h8, 4'h8,
                                 4'h5, 4'h5, 4'h0, 4'hC, 4'h6, 4'h6, 4'h1};
    logic [W-1:0] t_a   [15] = '{8'h7F, 8'h90, 8'h81, 8'h81, 8'h81, 8'hFF, 8'h05, 8'h03,
                                 8'h81, 8'h81, 8'h12, 8'h55, 8'd12, 8'd20, 8'hFF};
    logic [W-1:0] t_b   [15] = '{8'h01, 8'h02, 8'h01, 8'h01, 8'h09, 8'h01, 8'h05, 8'h05,
                                 8'h00, 8'h01, 8'hA5, 8'hAA, 8'd11, 8'd20, 8'h01};
    exp_t         t_exp [15] = '{
      '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
      '{8'hE4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{8'hC0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{8'h84, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{8'h90, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
      '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}};
    exp_t obs;
    int   extra, busy, lat_exp, busy_exp;
    for (int i = 0; i < 15; i++) begin
      issue_op(t_op[i], t_a[i], t_b[i], obs, extra, busy);
      lat_exp  = (t_op[i] == 4'h6) ? W : 0;
      busy_exp = (t_op[i] == 4'h6) ? W : 0;
      checks++;
      if (obs !== t_exp[i]) begin
        failures++;
        $display("FAIL directed[%0d] op=%h a=%h b=%h: got %h required %h",
                 i, t_op[i], t_a[i], t_b[i], obs, t_exp[i]);
      end
      checks++;
      if (extra !== lat_exp || busy !== busy_exp) begin
        failures++;
        $display("FAIL directed_timing[%0d]: extra_edges=%0d busy=%0d required %0d/%0d",
                 i, extra, busy, lat_exp, busy_exp);
      end
    end
  endtask

  task automatic test_random();
    exp_t         obs, exp_v;
    int           extra, busy;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom);
      exp_v = model(op, a, b);
      issue_op(op, a, b, obs, extra, busy);
      checks++;
      if (obs !== exp_v || extra !== ((op == 4'h6) ? W : 0)) begin
        failures++;
        $display("FAIL random[%0d] op=%h a=%h b=%h: got %h extra=%0d required %h extra=%0d",
                 i, op, a, b, obs, extra, exp_v, (op == 4'h6) ? W : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t         exp_v;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h6) op = 4'h8;
      a = W'($urandom); b = W'($urandom);
      exp_v = model(op, a, b);
      checks++;
      if (IN_READY !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, IN_READY);
      end
      IN_VALID = 1'b1; OP = op; DATA1 = a; DATA2 = b;
      @(posedge CLK); #1;
      checks++;
      if (OUT_VALID !== 1'b1 || observed() !== exp_v) begin
        failures++;
        $display("FAIL b2b[%0d] op=%h a=%h b=%h: valid=%b got %h required %h",
                 i, op, a, b, OUT_VALID, observed(), exp_v);
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t         exp_v, held;
    logic [W-1:0] a, b;
    int           bad = 0;
    int           seen = 0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    a = W'($urandom); b = W'($urandom);
    exp_v = model(4'h1, a, b);
    IN_VALID = 1'b1; OP = 4'h1; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    OP = 4'h6; DATA1 = W'($urandom); DATA2 = W'($urandom);
    held = observed();
    checks++;
    if (OUT_VALID !== 1'b1 || held !== exp_v) begin
      failures++;
      $display("FAIL bp_add: valid=%b got %h required %h", OUT_VALID, held, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || observed() !== held) bad++;
      @(posedge CLK); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stable: %0d unstable cycles, required 0", bad);
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_comb: in_ready=%b required 1", IN_READY);
    end
    @(posedge CLK); #1;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: valid=%b in_ready=%b required 0/1", OUT_VALID, IN_READY);
    end
    for (int i = 0; i < 12; i++) begin
      if (OUT_VALID !== 1'b0) seen++;
      @(posedge CLK); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL bp_no_mul: out_valid high %0d cycles, required 0", seen);
    end
  endtask

  task automatic test_reset_mid_mul();
    exp_t obs, exp_v;
    int   extra, busy;
    int   seen = 0;
    int   guard = 0;
    OUT_READY = 1'b1;
    while (!IN_READY && guard < 50) begin @(posedge CLK); #1; guard++; end
    IN_VALID = 1'b1; OP = 4'h6; DATA1 = 8'd13; DATA2 = 8'd7;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b0; IN_VALID = 1'b1; OP = 4'h1;
    @(posedge CLK); #1;
    RESET_N = 1'b1; IN_VALID = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0 || observed() !== exp_t'(0) || IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL midmul_reset: valid=%b outs=%h in_ready=%b required 0/%h/1",
               OUT_VALID, observed(), IN_READY, exp_t'(0));
    end
    for (int i = 0; i < 12; i++) begin
      if (OUT_VALID !== 1'b0) seen++;
      @(posedge CLK); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midmul_abort: out_valid high %0d cycles, required 0", seen);
    end
    exp_v = model(4'hC, 8'h3C, 8'hC3);
    issue_op(4'hC, 8'h3C, 8'hC3, obs, extra, busy);
    checks++;
    if (obs !== exp_v || extra !== 0) begin
      failures++;
      $display("FAIL midmul_illegal: got %h extra=%0d required %h extra=0", obs, extra, exp_v);
    end
  endtask

  initial begin
    RESET_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    OP = '0; DATA1 = '0; DATA2 = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
